// File: rtl/mono_video_pkg.sv
// Shared types and helpers for the mono video shaper: timing bundle, palette storage and ramp values.
package mono_video_pkg;

  localparam int PAL_LEVEL_BITS = 2;
  localparam int PAL_OUT_BITS   = 8;

  typedef logic [PAL_OUT_BITS-1:0] pal_word_t;
  typedef pal_word_t pal_array_t [2**PAL_LEVEL_BITS];

  typedef struct packed {
    logic de;
    logic hblank;
    logic vblank;
    logic hsync;
    logic vsync;
  } vid_tim_t;

  localparam vid_tim_t TIM_RESET = '{de: 1'b0, hblank: 1'b1, vblank: 1'b1, hsync: 1'b0, vsync: 1'b0};

  // Evenly spaced grey ramp from black to full white across all level codes.
  function automatic int pal_ramp(input int idx, input int level_bits, input int out_bits);
    return (idx * ((1 << out_bits) - 1)) / ((1 << level_bits) - 1);
  endfunction

endpackage

// File: rtl/mono_ce_div.sv
// Programmable pixel clock-enable divider: tick every div_i+1 clocks, registered copy on ce_pix_o.
module mono_ce_div #(
  parameter int DIV_W = 3
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [DIV_W-1:0] div_i,
  output logic             ce_tick_o,
  output logic             ce_pix_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d;
  logic             tick_s;

  // Comparing with >= lets a lowered divisor wrap at once instead of running to overflow.
  always_comb begin
    tick_s = (cnt_q >= div_i);
    ce_d   = tick_s;
    if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Counter and enable registers.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce_tick_o = tick_s;
  assign ce_pix_o  = ce_q;

endmodule

// File: rtl/mono_video_shaper.sv
// Level code to greyscale luma through a writable palette, with delay-matched blank/sync and pixel ce.
// Optional line-darkening scanline effect when MONO_VID_SCANLINE_EN is defined.
module mono_video_shaper
  import mono_video_pkg::*;
#(
  parameter int LEVEL_BITS = 2,
  parameter int OUT_BITS   = 8,
  parameter int DIV_W      = 3
) (
  input  logic                  Clk_I,
  input  logic                  Reset_I,
  input  logic [DIV_W-1:0]      Div_I,
  input  logic [LEVEL_BITS-1:0] Level_I,
  input  logic                  HBlank_I,
  input  logic                  VBlank_I,
  input  logic                  HSync_I,
  input  logic                  VSync_I,
  input  logic                  Pal_We_I,
  input  logic [LEVEL_BITS-1:0] Pal_Addr_I,
  input  logic [OUT_BITS-1:0]   Pal_Data_I,
`ifdef MONO_VID_SCANLINE_EN
  input  logic                  Scan_En_I,
`endif
  output logic                  Ce_Pix_O,
  output logic [OUT_BITS-1:0]   Luma_O,
  output logic                  HBlank_O,
  output logic                  VBlank_O,
  output logic                  HSync_O,
  output logic                  VSync_O,
  output logic                  De_O
);

  localparam int PAL_N = 2**LEVEL_BITS;

  logic                  ce_tick_s;
  logic [LEVEL_BITS-1:0] s1_level_q, s1_level_d;
  vid_tim_t              s1_tim_q, s1_tim_d;
  vid_tim_t              out_tim_q, out_tim_d;
  logic [OUT_BITS-1:0]   luma_q, luma_d;
  logic [OUT_BITS-1:0]   pal_q [PAL_N];
  logic [OUT_BITS-1:0]   pal_d [PAL_N];
  logic [OUT_BITS-1:0]   rd_word_s;
  logic [OUT_BITS-1:0]   pix_s;

  mono_ce_div #(.DIV_W(DIV_W)) u_ce_div (
    .clk_i    (Clk_I),
    .reset_ni (Reset_I),
    .div_i    (Div_I),
    .ce_tick_o(ce_tick_s),
    .ce_pix_o (Ce_Pix_O)
  );

  assign rd_word_s = pal_q[s1_level_q];

`ifdef MONO_VID_SCANLINE_EN
  logic par_q, par_d;

  // Line parity follows the rising sync edges as they enter stage 1; vsync wins over hsync.
  always_comb begin
    par_d = par_q;
    if (ce_tick_s) begin
      if (VSync_I && !s1_tim_q.vsync) begin
        par_d = 1'b0;
      end else if (HSync_I && !s1_tim_q.hsync) begin
        par_d = ~par_q;
      end else begin
        par_d = par_q;
      end
    end else begin
      par_d = par_q;
    end
    if (par_q && Scan_En_I) begin
      pix_s = rd_word_s >> 1;
    end else begin
      pix_s = rd_word_s;
    end
  end

  // Parity register.
  always_ff @(posedge Clk_I) begin
    if (!Reset_I) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`else
  assign pix_s = rd_word_s;
`endif

  // Two-stage pipeline gated by the pixel tick, plus palette writes on any clock.
  always_comb begin
    s1_level_d = s1_level_q;
    s1_tim_d   = s1_tim_q;
    luma_d     = luma_q;
    out_tim_d  = out_tim_q;
    pal_d      = pal_q;
    if (ce_tick_s) begin
      s1_level_d      = Level_I;
      s1_tim_d.hblank = HBlank_I;
      s1_tim_d.vblank = VBlank_I;
      s1_tim_d.hsync  = HSync_I;
      s1_tim_d.vsync  = VSync_I;
      s1_tim_d.de     = ~(HBlank_I | VBlank_I);
      out_tim_d       = s1_tim_q;
      if (s1_tim_q.hblank || s1_tim_q.vblank) begin
        luma_d = '0;
      end else begin
        luma_d = pix_s;
      end
    end else begin
      s1_level_d = s1_level_q;
    end
    // The read above uses pal_q, so a same-clock write is seen from the next tick on.
    if (Pal_We_I) begin
      pal_d[Pal_Addr_I] = Pal_Data_I;
    end else begin
      pal_d = pal_q;
    end
  end

  // Pipeline and palette registers; reset flushes to blank and restores the ramp.
  always_ff @(posedge Clk_I) begin
    if (!Reset_I) begin
      s1_level_q <= '0;
      s1_tim_q   <= TIM_RESET;
      out_tim_q  <= TIM_RESET;
      luma_q     <= '0;
      for (int i = 0; i < PAL_N; i++) begin
        pal_q[i] <= OUT_BITS'(pal_ramp(i, LEVEL_BITS, OUT_BITS));
      end
    end else begin
      s1_level_q <= s1_level_d;
      s1_tim_q   <= s1_tim_d;
      out_tim_q  <= out_tim_d;
      luma_q     <= luma_d;
      pal_q      <= pal_d;
    end
  end

  assign Luma_O   = luma_q;
  assign HBlank_O = out_tim_q.hblank;
  assign VBlank_O = out_tim_q.vblank;
  assign HSync_O  = out_tim_q.hsync;
  assign VSync_O  = out_tim_q.vsync;
  assign De_O     = out_tim_q.de;

endmodule

// File: tb/tb_mono_video_shaper.sv
// Self-checking bench for mono_video_shaper: directed tables, corner sequences, and random vs a reference model.
module tb_mono_video_shaper;
  import mono_video_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] div;
  logic [1:0] level;
  logic       hb, vb, hs, vs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] data;
  logic       ce;
  logic [7:0] luma;
  logic       hbo, vbo, hso, vso, deo;
`ifdef MONO_VID_SCANLINE_EN
  logic       scan_en;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  mono_video_shaper dut (
    .Clk_I(clk), .Reset_I(rst_n), .Div_I(div), .Level_I(level),
    .HBlank_I(hb), .VBlank_I(vb), .HSync_I(hs), .VSync_I(vs),
    .Pal_We_I(we), .Pal_Addr_I(addr), .Pal_Data_I(data),
`ifdef MONO_VID_SCANLINE_EN
    .Scan_En_I(scan_en),
`endif
    .Ce_Pix_O(ce), .Luma_O(luma), .HBlank_O(hbo), .VBlank_O(vbo),
    .HSync_O(hso), .VSync_O(vso), .De_O(deo)
  );

  always #5 clk = ~clk;

  // Reference model: pixel enable every div+1 clocks, samples travel through a two-slot queue.
  typedef struct {logic [1:0] lvl; logic h, v, hsy, vsy;} samp_t;
  int         m_since;
  logic       m_ce;
  pal_array_t m_pal;
  samp_t      m_s1;
  logic [7:0] m_luma;
  logic       m_ho, m_vo, m_hso, m_vso;
  logic       m_par;

  task automatic model_edge();
    logic [7:0] w;
    samp_t nw;
    if (!rst_n) begin
      m_since = 0; m_ce = 1'b0; m_luma = 8'h00;
      m_ho = 1'b1; m_vo = 1'b1; m_hso = 1'b0; m_vso = 1'b0;
      m_s1 = '{lvl: 2'd0, h: 1'b1, v: 1'b1, hsy: 1'b0, vsy: 1'b0};
      for (int i = 0; i < 4; i++) m_pal[i] = 8'((i * 255) / 3);
      m_par = 1'b0;
    end else begin
      m_ce = (m_since >= int'(div));
      m_since = m_ce ? 0 : m_since + 1;
      if (m_ce) begin
        w = m_pal[m_s1.lvl];
`ifdef MONO_VID_SCANLINE_EN
        if (m_par && scan_en) w = w / 8'd2;
`endif
        m_luma = (m_s1.h || m_s1.v) ? 8'h00 : w;
        m_ho = m_s1.h; m_vo = m_s1.v; m_hso = m_s1.hsy; m_vso = m_s1.vsy;
        nw = '{lvl: level, h: hb, v: vb, hsy: hs, vsy: vs};
        if (nw.vsy && !m_s1.vsy) m_par = 1'b0;
        else if (nw.hsy && !m_s1.hsy) m_par = !m_par;
        m_s1 = nw;
      end
      if (we) m_pal[addr] = data;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", {18'd0, ce, luma, hbo, vbo, hso, vso, deo},
        {18'd0, m_ce, m_luma, m_ho, m_vo, m_hso, m_vso, !(m_ho || m_vo)});
  endtask

  typedef struct {
    logic [1:0] lvl; logic h, v, hsy, vsy;
    logic [7:0] e_luma; logic e_de;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int n_ce;
    int cnt;
    tbl[0] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[1] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1};
    tbl[2] = '{2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b1};
    tbl[3] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1};
    tbl[4] = '{2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[5] = '{2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0};
    tbl[6] = '{2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1};
    tbl[7] = '{2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};

    rst_n = 1'b0; div = 3'd7; level = 2'd0; hb = 1'b0; vb = 1'b0; hs = 1'b0; vs = 1'b0;
    we = 1'b0; addr = 2'd0; data = 8'h00;
`ifdef MONO_VID_SCANLINE_EN
    scan_en = 1'b0;
`endif
    step(); step();
    chk("reset_outputs", {25'd0, ce, hbo, vbo, hso, vso, deo}, {25'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("reset_luma", {24'd0, luma}, 32'h0);

    // Divide by 8, level advances on each pixel enable.
    rst_n = 1'b1;
    n_ce = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      chk("ce_div8", {31'd0, ce}, {31'd0, (n % 8) == 0});
      if (ce) begin
        n_ce++;
        if (n_ce >= 2 && n_ce <= 5) chk("ramp_luma", {24'd0, luma}, {24'd0, 8'((((n_ce - 2) * 255) / 3))});
        level = 2'(n_ce);
      end
    end

    // Div 0 holds enable high; lowering the divisor below the count wraps next clock.
    div = 3'd0;
    for (int n = 0; n < 5; n++) begin step(); chk("ce_div0", {31'd0, ce}, 32'd1); end
    div = 3'd7;
    cnt = 0;
    while (m_since != 5 && cnt < 20) begin step(); cnt++; end
    chk("reach_cnt5", {31'd0, cnt < 20}, 32'd1);
    div = 3'd2;
    for (int n = 0; n < 7; n++) begin
      step();
      chk("ce_lowered", {31'd0, ce}, {31'd0, (n % 3) == 0});
    end

    // Table: pixel enable every clock, each vector shows up two enables later.
    div = 3'd0;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        level = tbl[i].lvl; hb = tbl[i].h; vb = tbl[i].v; hs = tbl[i].hsy; vs = tbl[i].vsy;
      end
      step();
      if (i >= 1)
        chk("table", {19'd0, luma, hbo, vbo, hso, vso, deo},
            {19'd0, tbl[i-1].e_luma, tbl[i-1].h, tbl[i-1].v, tbl[i-1].hsy, tbl[i-1].vsy, tbl[i-1].e_de});
    end

    // Palette write colliding with a read of the same entry.
    level = 2'd1; hb = 1'b0; vb = 1'b0; hs = 1'b0; vs = 1'b0;
    step(); step(); step();
    we = 1'b1; addr = 2'd1; data = 8'h50;
    step();
    we = 1'b0;
    chk("wr_old_value", {24'd0, luma}, 32'h55);
    step();
    chk("wr_new_value", {24'd0, luma}, 32'h50);

    // Mid-line reset after palette writes restores outputs and the ramp.
    we = 1'b1; addr = 2'd2; data = 8'h12;
    step();
    we = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midreset_outputs", {17'd0, ce, luma, hbo, vbo, hso, vso, deo},
        {17'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    step(); step(); step();
    chk("ramp_restored_1", {24'd0, luma}, 32'h55);
    level = 2'd2;
    step(); step();
    chk("ramp_restored_2", {24'd0, luma}, 32'hAA);

`ifdef MONO_VID_SCANLINE_EN
    level = 2'd3; scan_en = 1'b1;
    vs = 1'b1; step(); vs = 1'b0; step(); step();
    chk("scan_even", {24'd0, luma}, 32'hFF);
    hs = 1'b1; step(); hs = 1'b0; step();
    chk("scan_odd", {24'd0, luma}, 32'h7F);
    hs = 1'b1; step(); hs = 1'b0; step();
    chk("scan_even2", {24'd0, luma}, 32'hFF);
    hs = 1'b1; step(); hs = 1'b0; step();
    vs = 1'b1; step(); vs = 1'b0; step();
    chk("scan_vsync_even", {24'd0, luma}, 32'hFF);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 24) == 0) div = 3'($urandom_range(0, 7));
      level = 2'($urandom_range(0, 3));
      hb = ($urandom_range(0, 5) == 0);
      vb = ($urandom_range(0, 9) == 0);
      hs = ($urandom_range(0, 3) == 0);
      vs = ($urandom_range(0, 7) == 0);
      we = ($urandom_range(0, 7) == 0);
      addr = 2'($urandom_range(0, 3));
      data = 8'($urandom_range(0, 255));
      rst_n = ($urandom_range(0, 99) != 0);
`ifdef MONO_VID_SCANLINE_EN
      scan_en = ($urandom_range(0, 1) == 1);
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
